// File: rtl/alu_flags_reg_pkg.sv
// rtl/alu_flags_reg_pkg.sv - shared cpu types: flag indices, ALU class enum, flag vector type
package alu_flags_reg_pkg;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_S = 2;
  localparam int FLAG_O = 3;

  // Flag vector shared with the branch condition evaluator
  typedef logic [3:0] flags_t;

  typedef enum logic [1:0] {
    LOGIC = 2'b00,
    ADD   = 2'b01,
    SUB   = 2'b10,
    SHIFT = 2'b11
  } alu_class_t;

endpackage

// File: rtl/alu_flags_calc.sv
// rtl/alu_flags_calc.sv - combinational Z/C/S/O computation from one ALU operation
module alu_flags_calc
  import alu_flags_reg_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  alu_class_t        alu_class,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              shift_cout,
  output flags_t            computed
);

  logic              add_carry;
  logic [DATA_W-1:0] unused_sum;
  logic              a_msb;
  logic              b_msb;
  logic              r_msb;

  // Carry comes from a one-bit-wider sum; the low bits are the ALU's job, not ours
  assign {add_carry, unused_sum} = {1'b0, op_a} + {1'b0, op_b};
  assign a_msb = op_a[DATA_W-1];
  assign b_msb = op_b[DATA_W-1];
  assign r_msb = alu_result[DATA_W-1];

  // Z and S come straight from the result; C and O depend on the operation class
  always_comb begin
    computed         = '0;
    computed[FLAG_Z] = (alu_result == '0);
    computed[FLAG_S] = r_msb;
    case (alu_class)
      ADD: begin
        computed[FLAG_C] = add_carry;
        computed[FLAG_O] = (a_msb == b_msb) && (r_msb != a_msb);
      end
      SUB: begin
        computed[FLAG_C] = (op_a < op_b);
        computed[FLAG_O] = (a_msb != b_msb) && (r_msb != a_msb);
      end
      SHIFT: begin
        computed[FLAG_C] = shift_cout;
      end
      default: begin
        computed[FLAG_C] = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_flags_reg.sv
// rtl/alu_flags_reg.sv - architectural flag register with per-flag mask; shadow stack under FLAGS_SHADOW_EN
module alu_flags_reg
  import alu_flags_reg_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int SHADOW_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  alu_class_t        alu_class,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              shift_cout,
  input  logic [3:0]        flag_we,
  input  logic              save,
  input  logic              restore,
  output flags_t            flags,
  output logic              shadow_ovf,
  output logic              shadow_unf
);

  flags_t computed;
  flags_t flags_d;

  alu_flags_calc #(.DATA_W(DATA_W)) u_calc (
    .alu_class  (alu_class),
    .op_a       (op_a),
    .op_b       (op_b),
    .alu_result (alu_result),
    .shift_cout (shift_cout),
    .computed   (computed)
  );

  // Masked next-state: only enabled flags of a valid ALU op change
  always_comb begin
    flags_d = flags;
    for (int i = 0; i < 4; i++) begin
      if (alu_valid && flag_we[i]) begin
        flags_d[i] = computed[i];
      end
    end
  end

`ifdef FLAGS_SHADOW_EN
  localparam int PTR_W = $clog2(SHADOW_DEPTH + 1);
  localparam int IDX_W = (SHADOW_DEPTH > 1) ? $clog2(SHADOW_DEPTH) : 1;

  flags_t           stack_mem [SHADOW_DEPTH];
  logic [PTR_W-1:0] sp;
  logic             stack_full;
  logic             stack_empty;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] top_idx;

  assign stack_full  = (sp == PTR_W'(SHADOW_DEPTH));
  assign stack_empty = (sp == '0);
  assign push_idx    = sp[IDX_W-1:0];
  assign top_idx     = IDX_W'(sp - PTR_W'(1));

  // Flags, stack pointer and sticky errors; restore beats save and any ALU update
  always_ff @(posedge clk) begin
    if (reset) begin
      flags      <= '0;
      sp         <= '0;
      shadow_ovf <= 1'b0;
      shadow_unf <= 1'b0;
    end else if (restore) begin
      if (stack_empty) begin
        flags      <= flags_d;
        shadow_unf <= 1'b1;
      end else begin
        flags <= stack_mem[top_idx];
        sp    <= sp - PTR_W'(1);
      end
    end else begin
      flags <= flags_d;
      if (save) begin
        if (stack_full) begin
          shadow_ovf <= 1'b1;
        end else begin
          sp <= sp + PTR_W'(1);
        end
      end
    end
  end

  // Stack storage needs no reset; the pointer alone defines what is live
  always_ff @(posedge clk) begin
    if (!reset && !restore && save && !stack_full) begin
      stack_mem[push_idx] <= flags_d;
    end
  end
`else
  logic unused_shadow;
  assign unused_shadow = save ^ restore ^ (SHADOW_DEPTH > 0);
  assign shadow_ovf    = 1'b0;
  assign shadow_unf    = 1'b0;

  // Plain masked flag register
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= '0;
    end else begin
      flags <= flags_d;
    end
  end
`endif

endmodule

// File: doc/alu_flags_reg.md
# alu_flags_reg

Producer side of the condition-flag interface. Computes Z/C/S/O from each ALU operation, holds them in an architectural flag register under a per-flag write mask from the UC, and drives the 4-bit flag vector read by the branch condition evaluator. An optional shadow stack saves and restores flags across interrupt entry and return.

## Interface
- DATA_W, 32: ALU operand and result width.
- SHADOW_DEPTH, 4: shadow stack entries; used only with FLAGS_SHADOW_EN.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result on this cycle's inputs is valid.
- alu_class  in  2  00 logic, 01 add, 10 sub, 11 shift.
- op_a, op_b  in  DATA_W  ALU operands.
- alu_result  in  DATA_W  ALU result.
- shift_cout  in  1  last bit shifted out; shift class only.
- flag_we  in  4  per-flag write mask from UC; bit index = flag index.
- save  in  1  push current flags to shadow stack (interrupt entry).
- restore  in  1  pop shadow stack into flags (interrupt return).
- flags  out  4  registered flags: Z=0, C=1, S=2, O=3.
- shadow_ovf  out  1  sticky: save while stack full.
- shadow_unf  out  1  sticky: restore while stack empty.

## Operation
- Computed flags, valid in the same cycle as alu_valid:
  - Z = (alu_result == 0).
  - S = alu_result[DATA_W-1].
  - add: C = carry out of the (DATA_W+1)-bit sum op_a+op_b; O = (a_msb==b_msb) && (r_msb!=a_msb).
  - sub: C = borrow, i.e. op_a < op_b unsigned; O = (a_msb!=b_msb) && (r_msb!=a_msb).
  - logic: C=0, O=0. Shift: C=shift_cout, O=0.
- Update: flags_d[i] = (alu_valid && flag_we[i]) ? computed[i] : flags[i]. Unmasked bits hold.
- alu_valid=0: flag_we is ignored, flags hold.
- Restore overrides any same-cycle ALU update.

## Timing
- Reset: flags=4'b0000, stack empty, shadow_ovf=0, shadow_unf=0.
- Latency: 1 cycle. A write on cycle N is visible on flags in cycle N+1. A branch in cycle N sees the pre-update value; the UC handles this hazard.
- No handshake back-pressure. The block accepts every alu_valid.
- Reset mid-operation: reset wins over alu_valid, save and restore on that edge. Stack contents are discarded.

## Configuration
- FLAGS_SHADOW_EN defined:
  - save pushes flags_d, which includes a same-cycle ALU update.
  - restore pops the top entry into flags.
  - Save while full: entry dropped, stack unchanged, shadow_ovf set.
  - Restore while empty: flags take flags_d, shadow_unf set.
  - save and restore in the same cycle: restore only; save is ignored.
  - Stack pointer is $clog2(SHADOW_DEPTH+1) bits with no wrap-around.
  - Sticky bits clear only on reset.
- FLAGS_SHADOW_EN undefined: save and restore are ignored, no stack storage is built, and shadow_ovf and shadow_unf are tied 0.

## Structure
- Shared cpu package holds:
  - Flag index constants FLAG_Z=0, FLAG_C=1, FLAG_S=2, FLAG_O=3.
  - alu_class enum: LOGIC, ADD, SUB, SHIFT.
  - A 4-bit flags_t typedef, shared with the branch condition evaluator.
- Sub-module alu_flags_calc: purely combinational flag computation (inputs: class, operands, result, shift_cout). The parent holds the register, mask logic and shadow stack.

## Test plan
- Reset, then idle: flags=0000. add 0x7FFFFFFF+1, result 0x80000000, flag_we=1111 → next cycle flags: O=1, S=1, C=0, Z=0.
- sub 5−5, result 0, flag_we=0001 → only Z=1; C, S, O keep prior values. sub 3−5 with flag_we=1111 → C=1, S=1, Z=0, O=0.
- add 0xFFFFFFFF+1, result 0, flag_we=1111 → Z=1, C=1, S=0, O=0. Same op with alu_valid=0 → flags unchanged.
- Shadow (FLAGS_SHADOW_EN):
  - 4 saves then a 5th save → shadow_ovf=1.
  - 4 restores return the saved values in LIFO order.
  - A 5th restore → shadow_unf=1, flags hold.
- Shadow, simultaneous events:
  - save with an ALU update in the same cycle → the pushed value equals the updated flags.
  - restore with alu_valid → the popped value wins.
  - reset asserted mid-sequence → all state returns to reset values.
